fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage of the rysy core, sitting directly upstream of `ctrl`. It owns the program counter and issues one request at a time on a req/gnt/rvalid instruction-memory port. It presents the current instruction to decode/`ctrl` with a valid strobe. Each cycle it consumes `ctrl`'s `pc_sel` and `inst_sel` to pick the next PC and to fetch, replay, or inject a NOP.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC after reset.
- `NOP_INST`, default 32'h0000_0013: encoding injected for NOP slots (`addi x0,x0,0`).

Ports:
- `clk`  in  1  clock
- `rst`  in  1  synchronous, active-high reset
- `pc_sel`  in  pcPkg::pc_sel  next-PC select from `ctrl`
- `inst_sel`  in  instMgmtPkg::inst_sel  next-slot select from `ctrl`
- `alu_out`  in  32  ALU result (jump/branch target)
- `imem_req`  out  1  request valid
- `imem_addr`  out  32  request address, word aligned
- `imem_gnt`  in  1  request accepted
- `imem_rvalid`  in  1  response valid (one per granted request)
- `imem_rdata`  in  32  response data
- `inst`  out  32  current instruction
- `inst_valid`  out  1  `inst`/`pc` valid; `ctrl` outputs are sampled only when 1
- `pc`  out  32  PC of `inst`
- `fetch_fault`  out  1  sticky misaligned-target flag

## Operation
- FSM states: F_IDLE, F_REQ, F_WAIT, F_EXEC, and F_FAULT (F_FAULT exists only with the macro).
- F_IDLE goes to F_REQ unconditionally.
- F_REQ:
  - `imem_req`=1 and `imem_addr`=`pc`, both held stable until `imem_gnt`.
  - On `gnt`, go to F_WAIT.
- F_WAIT:
  - On `rvalid`, `inst`<=`imem_rdata` and go to F_EXEC.
  - `rvalid` outside F_WAIT is ignored.
- F_EXEC: `inst_valid`=1. The unit samples `pc_sel`, `inst_sel` and `alu_out`.
  - The PC is updated per `pc_sel`:
    - P4: `pc`+4
    - M4: `pc`-4
    - OLD: `pc`
    - ALU: `{alu_out[31:2],2'b00}`
  - Arithmetic is modulo 2^32. Wrap-around is legal and silent.
  - `inst_sel` MEM: go to F_REQ.
  - `inst_sel` OLD: stay in F_EXEC with `inst` unchanged. This is the replay used for load phase 2.
  - `inst_sel` NOP: stay in F_EXEC with `inst`=`NOP_INST` and `nop_slot`=1.
- NOP slot rules:
  - `pc_sel` and `inst_sel` are ignored.
  - `pc` holds.
  - The next state is F_REQ.
- Reset with a granted request outstanding (F_WAIT at reset):
  - A `kill_q` flag is set.
  - The next `rvalid` is dropped and clears `kill_q`.
  - F_REQ may issue while `kill_q`=1. The first `rvalid` after reset still belongs to the killed request and is dropped.

## Timing
- Reset values:
  - `imem_req`=0, `imem_addr`=`RESET_PC`
  - `inst`=`NOP_INST`, `inst_valid`=0
  - `pc`=`RESET_PC`, `fetch_fault`=0
  - state F_IDLE, `nop_slot`=0
  - `kill_q` set as described in Operation
- The first `imem_req` asserts 2 cycles after `rst` falls (F_IDLE, then F_REQ).
- Best-case instruction period is 3 cycles: REQ with same-cycle `gnt`, then WAIT with `rvalid`, then EXEC.
  - Each extra `gnt` or `rvalid` wait cycle adds 1 cycle.
- Memory protocol: `rvalid` comes no earlier than the cycle after `gnt`.
- An OLD replay adds exactly 1 EXEC cycle. A NOP slot adds exactly 1 EXEC cycle with no memory traffic.
- `pc` and `inst` change only on F_EXEC exits and `rvalid` captures. They are stable throughout each EXEC cycle.

## Configuration
- `FETCH_MISALIGN_CHK_EN` defined:
  - In F_EXEC with `pc_sel`=ALU and `alu_out[1:0]`!=0: `fetch_fault`<=1, `pc`<=unaligned target, go to F_FAULT.
  - F_FAULT: no requests, `inst_valid`=0. Only `rst` exits.
- Not defined:
  - Target bits [1:0] are forced to 0 silently.
  - `fetch_fault` is tied to 0 and F_FAULT does not exist.

## Structure
- Shared package `fetchPkg` holds:
  - `fetch_state` enum
  - `NOP_ENC` constant, used as the default for `NOP_INST`
- Reuse `pcPkg` and `instMgmtPkg` unchanged.
- One sub-module, `pc_next_calc`: combinational next-PC from `pc`, `pc_sel` and `alu_out`, plus the misalign flag.

## Test plan
- Reset with `gnt` tied 1 and `rvalid` one cycle after `gnt`, `pc_sel`=P4, `inst_sel`=MEM:
  - `imem_addr` runs 0x0, 0x4, 0x8.
  - `inst_valid` pulses every 3rd cycle.
  - `inst` equals the memory word each time.
- Jump at `pc`=0x10 with `alu_out`=0x100, `pc_sel`=ALU, `inst_sel`=NOP:
  - Next EXEC shows `inst`=0x00000013 with `pc`=0x100.
  - The next `imem_addr` is 0x100.
- Load replay: EXEC at `pc`=0x20 with `inst_sel`=OLD and `pc_sel`=M4:
  - Two consecutive EXEC cycles with the same `inst`.
  - `pc` is 0x1C in the second cycle.
- Stall `gnt` for 5 cycles and `rvalid` for 3: `imem_req` and `imem_addr` stay constant, and `inst_valid` stays 0 throughout.
- Reset asserted in F_WAIT, then a stale `rvalid` with 0xDEADBEEF arrives: it is dropped, and the first EXEC after reset shows the word fetched from `RESET_PC`.
- With `FETCH_MISALIGN_CHK_EN`, `pc_sel`=ALU and `alu_out`=0x102:
  - `fetch_fault`=1 and `imem_req` stays 0 until `rst`.
- Without the macro, the same stimulus gives the next `imem_addr`=0x100.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Packages for the rysy fetch stage: next-PC and next-slot selects, FSM states.
// Optional build macro: FETCH_MISALIGN_CHK_EN (adds the F_FAULT state).
package pcPkg;
  typedef enum logic [1:0] {
    P4  = 2'd0,
    M4  = 2'd1,
    OLD = 2'd2,
    ALU = 2'd3
  } pc_sel;
endpackage

package instMgmtPkg;
  typedef enum logic [1:0] {
    MEM = 2'd0,
    OLD = 2'd1,
    NOP = 2'd2
  } inst_sel;
endpackage

package fetchPkg;
  localparam logic [31:0] NOP_ENC = 32'h0000_0013;

  typedef enum logic [2:0] {
    F_IDLE  = 3'd0,
    F_REQ   = 3'd1,
    F_WAIT  = 3'd2,
`ifdef FETCH_MISALIGN_CHK_EN
    F_EXEC  = 3'd3,
    F_FAULT = 3'd4
`else
    F_EXEC  = 3'd3
`endif
  } fetch_state;
endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory port: one outstanding req/gnt, one rvalid per grant.
// Optional build macro: none.
interface fetch_unit_if;
  logic        req;
  logic [31:0] addr;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (
    output req, addr,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, addr,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/fetch_unit_pc_next_calc.sv
// Combinational next-PC from the current PC, pc_sel and ALU target.
// Optional build macro: none (misalign is always computed).
module pc_next_calc (
  input  logic [31:0]  pc,
  input  pcPkg::pc_sel pc_sel,
  input  logic [31:0]  alu_out,
  output logic [31:0]  pc_next,
  output logic         misalign
);

  // Select next PC; ALU targets are word-aligned here.
  always_comb begin
    pc_next = pc + 32'd4;
    unique case (pc_sel)
      pcPkg::P4:  pc_next = pc + 32'd4;
      pcPkg::M4:  pc_next = pc - 32'd4;
      pcPkg::OLD: pc_next = pc;
      pcPkg::ALU: pc_next = {alu_out[31:2], 2'b00};
    endcase
  end

  assign misalign = (pc_sel == pcPkg::ALU) &&
                    (alu_out[1:0] != 2'b00);

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: owns the PC, fetches over imem, feeds ctrl with inst/valid.
// Optional build macro: FETCH_MISALIGN_CHK_EN (sticky fault on bad target).
module fetch_unit
  import fetchPkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = NOP_ENC
) (
  input  logic                   clk,
  input  logic                   rst,
  input  pcPkg::pc_sel           pc_sel,
  input  instMgmtPkg::inst_sel   inst_sel,
  input  logic [31:0]            alu_out,
  fetch_unit_if.master           imem,
  output logic [31:0]            inst,
  output logic                   inst_valid,
  output logic [31:0]            pc,
  output logic                   fetch_fault
);

  fetch_state  state;
  logic        req_q;
  logic        nop_slot;
  logic        kill_q;
  logic [31:0] pc_next;
  logic        misalign;

  pc_next_calc u_pc_next (
    .pc       (pc),
    .pc_sel   (pc_sel),
    .alu_out  (alu_out),
    .pc_next  (pc_next),
    .misalign (misalign)
  );

  assign imem.req  = req_q;
  assign imem.addr = {pc[31:2], 2'b00};

`ifndef FETCH_MISALIGN_CHK_EN
  logic unused_misalign;
  assign unused_misalign = misalign;
  assign fetch_fault     = 1'b0;
`endif

  // Fetch FSM; kill_q survives reset to drop a response already in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= F_IDLE;
      req_q      <= 1'b0;
      nop_slot   <= 1'b0;
      inst       <= NOP_INST;
      inst_valid <= 1'b0;
      pc         <= RESET_PC;
      kill_q     <= (kill_q || state == F_WAIT) && !imem.rvalid;
`ifdef FETCH_MISALIGN_CHK_EN
      fetch_fault <= 1'b0;
`endif
    end else begin
      if (kill_q && imem.rvalid)
        kill_q <= 1'b0;
      unique case (state)
        F_IDLE: begin
          state <= F_REQ;
          req_q <= 1'b1;
        end
        F_REQ: begin
          if (imem.gnt) begin
            state <= F_WAIT;
            req_q <= 1'b0;
          end
        end
        F_WAIT: begin
          if (imem.rvalid && !kill_q) begin
            inst       <= imem.rdata;
            inst_valid <= 1'b1;
            state      <= F_EXEC;
          end
        end
        F_EXEC: begin
          if (nop_slot) begin
            nop_slot   <= 1'b0;
            inst_valid <= 1'b0;
            req_q      <= 1'b1;
            state      <= F_REQ;
          end
`ifdef FETCH_MISALIGN_CHK_EN
          else if (misalign) begin
            fetch_fault <= 1'b1;
            pc          <= alu_out;
            inst_valid  <= 1'b0;
            state       <= F_FAULT;
          end
`endif
          else begin
            pc <= pc_next;
            unique case (inst_sel)
              instMgmtPkg::OLD: begin
              end
              instMgmtPkg::NOP: begin
                inst     <= NOP_INST;
                nop_slot <= 1'b1;
              end
              default: begin
                inst_valid <= 1'b0;
                req_q      <= 1'b1;
                state      <= F_REQ;
              end
            endcase
          end
        end
`ifdef FETCH_MISALIGN_CHK_EN
        F_FAULT: begin
          req_q      <= 1'b0;
          inst_valid <= 1'b0;
        end
`endif
        default: begin
          state      <= F_IDLE;
          req_q      <= 1'b0;
          inst_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a small latency-programmable memory.
// Optional build macro: FETCH_MISALIGN_CHK_EN selects the fault expectations.
module tb_fetch_unit;

  logic                 clk;
  logic                 rst;
  pcPkg::pc_sel         pc_sel;
  instMgmtPkg::inst_sel inst_sel;
  logic [31:0]          alu_out;
  logic [31:0]          inst;
  logic                 inst_valid;
  logic [31:0]          pc;
  logic                 fetch_fault;

  fetch_unit_if ifc ();

  fetch_unit dut (
    .clk         (clk),
    .rst         (rst),
    .pc_sel      (pc_sel),
    .inst_sel    (inst_sel),
    .alu_out     (alu_out),
    .imem        (ifc.master),
    .inst        (inst),
    .inst_valid  (inst_valid),
    .pc          (pc),
    .fetch_fault (fetch_fault)
  );

  int nvec = 0;
  int nmis = 0;

  bit          mem_auto;
  bit          hold_gnt;
  int          gnt_wait;
  int          rv_wait;
  logic        a_gnt, a_rvalid;
  logic [31:0] a_rdata;
  logic        m_gnt, m_rvalid;
  logic [31:0] m_rdata;
  bit          pend;
  logic [31:0] paddr;
  int          gcnt, rcnt;

  assign ifc.gnt    = mem_auto ? a_gnt    : m_gnt;
  assign ifc.rvalid = mem_auto ? a_rvalid : m_rvalid;
  assign ifc.rdata  = mem_auto ? a_rdata  : m_rdata;

  function automatic logic [31:0] word(input logic [31:0] a);
    return {16'hC0DE, a[15:0]};
  endfunction

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: grant after gnt_wait req cycles, respond rv_wait later.
  always @(negedge clk) begin
    if (!mem_auto) begin
      a_gnt = 1'b0; a_rvalid = 1'b0;
      pend = 1'b0; gcnt = 0; rcnt = 0;
    end else begin
      if (a_rvalid === 1'b1) pend = 1'b0;
      if (a_gnt === 1'b1) begin
        pend = 1'b1; rcnt = 0;
      end
      a_gnt = 1'b0; a_rvalid = 1'b0;
      if (pend) begin
        if (rcnt >= rv_wait) begin
          a_rvalid = 1'b1;
          a_rdata  = word(paddr);
        end else rcnt++;
      end else if (ifc.req === 1'b1 && !hold_gnt) begin
        if (gcnt >= gnt_wait) begin
          a_gnt = 1'b1; paddr = ifc.addr; gcnt = 0;
        end else gcnt++;
      end
    end
  end

  task automatic do_reset;
    @(posedge clk);
    #1;
    hold_gnt = 1'b1;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    hold_gnt = 1'b0;
    rst = 1'b0;
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 20 && !ok; n++) begin
      @(negedge clk);
      if (inst_valid === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic test_reset;
    do_reset();
    nvec++;
    if (ifc.req !== 1'b0) begin
      nmis++; $display("FAIL rst_req got %b want 0", ifc.req);
    end
    nvec++;
    if (ifc.addr !== 32'h0) begin
      nmis++; $display("FAIL rst_addr got %h want 0", ifc.addr);
    end
    nvec++;
    if (inst !== 32'h0000_0013) begin
      nmis++; $display("FAIL rst_inst got %h want 13", inst);
    end
    nvec++;
    if (inst_valid !== 1'b0) begin
      nmis++; $display("FAIL rst_valid got %b want 0", inst_valid);
    end
    nvec++;
    if (pc !== 32'h0) begin
      nmis++; $display("FAIL rst_pc got %h want 0", pc);
    end
    nvec++;
    if (fetch_fault !== 1'b0) begin
      nmis++; $display("FAIL rst_fault got %b want 0", fetch_fault);
    end
    @(negedge clk);
    nvec++;
    if (ifc.req !== 1'b1) begin
      nmis++; $display("FAIL first_req got %b want 1", ifc.req);
    end
  endtask

  task automatic test_sequential;
    logic        ereq, eval;
    logic [31:0] ea;
    do_reset();
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk);
      ereq = (i % 3 == 1);
      eval = (i % 3 == 0);
      nvec++;
      if (ifc.req !== ereq) begin
        nmis++; $display("FAIL seq_req c%0d got %b want %b", i, ifc.req, ereq);
      end
      nvec++;
      if (inst_valid !== eval) begin
        nmis++; $display("FAIL seq_valid c%0d got %b want %b", i, inst_valid, eval);
      end
      if (ereq) begin
        ea = 32'(4 * ((i - 1) / 3));
        nvec++;
        if (ifc.addr !== ea) begin
          nmis++; $display("FAIL seq_addr c%0d got %h want %h", i, ifc.addr, ea);
        end
      end
      if (eval) begin
        ea = 32'(4 * (i / 3 - 1));
        nvec++;
        if (inst !== word(ea)) begin
          nmis++; $display("FAIL seq_inst c%0d got %h want %h", i, inst, word(ea));
        end
        nvec++;
        if (pc !== ea) begin
          nmis++; $display("FAIL seq_pc c%0d got %h want %h", i, pc, ea);
        end
      end
    end
  endtask

  task automatic test_jump_nop;
    bit ok;
    do_reset();
    for (int k = 0; k < 5; k++) begin
      wait_valid(ok);
      nvec++;
      if (!ok) begin
        nmis++; $display("FAIL jmp_wait got timeout want valid");
      end
    end
    nvec++;
    if (pc !== 32'h10) begin
      nmis++; $display("FAIL jmp_pc0 got %h want 10", pc);
    end
    pc_sel = pcPkg::ALU; alu_out = 32'h100; inst_sel = instMgmtPkg::NOP;
    @(negedge clk);
    pc_sel = pcPkg::M4; inst_sel = instMgmtPkg::OLD;
    nvec++;
    if (inst_valid !== 1'b1) begin
      nmis++; $display("FAIL nop_valid got %b want 1", inst_valid);
    end
    nvec++;
    if (inst !== 32'h0000_0013) begin
      nmis++; $display("FAIL nop_inst got %h want 13", inst);
    end
    nvec++;
    if (pc !== 32'h100) begin
      nmis++; $display("FAIL nop_pc got %h want 100", pc);
    end
    @(negedge clk);
    pc_sel = pcPkg::P4; inst_sel = instMgmtPkg::MEM;
    nvec++;
    if (ifc.req !== 1'b1 || ifc.addr !== 32'h100) begin
      nmis++; $display("FAIL nop_next req %b addr %h want 1 100", ifc.req, ifc.addr);
    end
  endtask

  task automatic test_replay;
    bit ok;
    do_reset();
    for (int k = 0; k < 9; k++) begin
      wait_valid(ok);
      nvec++;
      if (!ok) begin
        nmis++; $display("FAIL rep_wait got timeout want valid");
      end
    end
    nvec++;
    if (pc !== 32'h20) begin
      nmis++; $display("FAIL rep_pc0 got %h want 20", pc);
    end
    pc_sel = pcPkg::M4; inst_sel = instMgmtPkg::OLD;
    @(negedge clk);
    pc_sel = pcPkg::P4; inst_sel = instMgmtPkg::MEM;
    nvec++;
    if (inst_valid !== 1'b1) begin
      nmis++; $display("FAIL rep_valid got %b want 1", inst_valid);
    end
    nvec++;
    if (inst !== word(32'h20)) begin
      nmis++; $display("FAIL rep_inst got %h want %h", inst, word(32'h20));
    end
    nvec++;
    if (pc !== 32'h1C) begin
      nmis++; $display("FAIL rep_pc got %h want 1c", pc);
    end
    @(negedge clk);
    nvec++;
    if (ifc.req !== 1'b1 || ifc.addr !== 32'h20) begin
      nmis++; $display("FAIL rep_next req %b addr %h want 1 20", ifc.req, ifc.addr);
    end
  endtask

  task automatic test_stall;
    logic ereq, eval;
    do_reset();
    gnt_wait = 5; rv_wait = 3;
    for (int i = 1; i <= 11; i++) begin
      @(negedge clk);
      ereq = (i <= 6);
      eval = (i == 11);
      nvec++;
      if (ifc.req !== ereq) begin
        nmis++; $display("FAIL stall_req c%0d got %b want %b", i, ifc.req, ereq);
      end
      nvec++;
      if (inst_valid !== eval) begin
        nmis++; $display("FAIL stall_valid c%0d got %b want %b", i, inst_valid, eval);
      end
      if (ereq) begin
        nvec++;
        if (ifc.addr !== 32'h0) begin
          nmis++; $display("FAIL stall_addr c%0d got %h want 0", i, ifc.addr);
        end
      end
    end
    nvec++;
    if (inst !== word(32'h0)) begin
      nmis++; $display("FAIL stall_inst got %h want %h", inst, word(32'h0));
    end
    gnt_wait = 0; rv_wait = 0;
  endtask

  task automatic test_misalign;
    bit ok;
    do_reset();
    wait_valid(ok);
    nvec++;
    if (!ok) begin
      nmis++; $display("FAIL mis_wait got timeout want valid");
    end
    pc_sel = pcPkg::ALU; alu_out = 32'h102;
    @(negedge clk);
    pc_sel = pcPkg::P4;
`ifdef FETCH_MISALIGN_CHK_EN
    nvec++;
    if (pc !== 32'h102) begin
      nmis++; $display("FAIL mis_pc got %h want 102", pc);
    end
    for (int i = 0; i < 6; i++) begin
      nvec++;
      if (fetch_fault !== 1'b1 || ifc.req !== 1'b0 || inst_valid !== 1'b0) begin
        nmis++;
        $display("FAIL mis_fault c%0d fault %b req %b valid %b want 1 0 0",
                 i, fetch_fault, ifc.req, inst_valid);
      end
      @(negedge clk);
    end
`else
    nvec++;
    if (ifc.req !== 1'b1 || ifc.addr !== 32'h100) begin
      nmis++; $display("FAIL mis_addr req %b addr %h want 1 100", ifc.req, ifc.addr);
    end
    nvec++;
    if (fetch_fault !== 1'b0) begin
      nmis++; $display("FAIL mis_nofault got %b want 0", fetch_fault);
    end
`endif
  endtask

  task automatic test_stale_kill;
    do_reset();
    mem_auto = 1'b0;
    m_gnt = 1'b0; m_rvalid = 1'b0; m_rdata = 32'h0;
    @(negedge clk);
    m_gnt = 1'b1;
    @(negedge clk);
    m_gnt = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    nvec++;
    if (ifc.req !== 1'b1 || ifc.addr !== 32'h0) begin
      nmis++; $display("FAIL kill_req req %b addr %h want 1 0", ifc.req, ifc.addr);
    end
    m_gnt = 1'b1;
    @(negedge clk);
    m_gnt = 1'b0; m_rvalid = 1'b1; m_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    m_rdata = word(32'h0);
    nvec++;
    if (inst_valid !== 1'b0) begin
      nmis++; $display("FAIL kill_drop valid %b inst %h want 0", inst_valid, inst);
    end
    @(negedge clk);
    m_rvalid = 1'b0;
    nvec++;
    if (inst_valid !== 1'b1 || inst !== word(32'h0)) begin
      nmis++;
      $display("FAIL kill_inst valid %b inst %h want 1 %h",
               inst_valid, inst, word(32'h0));
    end
    nvec++;
    if (pc !== 32'h0) begin
      nmis++; $display("FAIL kill_pc got %h want 0", pc);
    end
  endtask

  initial begin
    rst = 1'b1; hold_gnt = 1'b0; mem_auto = 1'b1;
    gnt_wait = 0; rv_wait = 0;
    pc_sel = pcPkg::P4; inst_sel = instMgmtPkg::MEM; alu_out = 32'h0;
    m_gnt = 1'b0; m_rvalid = 1'b0; m_rdata = 32'h0;
    test_reset();
    test_sequential();
    test_jump_nop();
    test_replay();
    test_stall();
    test_misalign();
    test_stale_kill();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
